pll_cen_gen: RTL and testbench

- Parametrised successor to the fixed-ratio PLL wrapper. It generates NUM_CH independent fractional clock-enable pulse trains from one PLL output clock, instead of consuming extra PLL output counters.
- Enables are lock-qualified: they stay off until the PLL lock is synchronised and stable for LOCK_DLY cycles.
- Per-channel ratios can be reprogrammed at run time through a valid/ready config port.
- Sits directly after the PLL; feeds CPU, video and audio clock-enable nets.

---
 rtl/pll_cen_gen_if.sv | 32 +++
 rtl/pll_cen_gen.sv | 164 ++++++++++++++++
 tb/tb_pll_cen_gen.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pll_cen_gen_if.sv
// Purpose : run-time ratio configuration port for pll_cen_gen (valid/ready).
// Latency : a write lands in the increment register on the accepting edge.
// Backpressure: the slave holds cfg_ready high whenever out of reset.
//
// Signals:
//   cfg_valid  master->slave  request
//   cfg_ready  slave->master  accept
//   cfg_ch     master->slave  target channel (out-of-range writes are dropped)
//   cfg_inc    master->slave  new phase increment
//   cfg_sync   master->slave  zero every accumulator on accept
interface pll_cen_gen_if #(
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 16
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_sync;

  modport master (
    output cfg_valid, cfg_ch, cfg_inc, cfg_sync,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_inc, cfg_sync,
    output cfg_ready
  );
endinterface

// File: rtl/pll_cen_gen.sv
// Purpose : NUM_CH fractional clock-enable pulse trains from one PLL clock, gated by PLL lock.
// Latency : cen is registered (1 cycle after the accumulator carry); new ratios apply the cycle after accept.
// Backpressure: none; config is always accepted out of reset, back-to-back writes allowed.
//
// Ports:
//   refclk      PLL output clock, the only clock
//   rst         asynchronous active-high reset
//   pll_locked  raw PLL lock, asynchronous to refclk
//   cfg         pll_cen_gen_if.slave config port (channel, increment, sync)
//   ready       lock qualified, enables running
//   cen         one-cycle enable pulses, one per channel
//   cen_n       (only with PLL_CEN_PHASE_EN) half-period-offset enable pulses
//
// Optional feature macro: PLL_CEN_PHASE_EN adds the cen_n output.
module pll_cen_gen #(
  parameter int                      NUM_CH   = 4,
  parameter int                      ACC_W    = 16,
  parameter int                      LOCK_DLY = 1024,
  parameter logic [NUM_CH*ACC_W-1:0] INIT_INC = {NUM_CH{16'h1000}}
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pll_locked,
  pll_cen_gen_if.slave      cfg,
  output logic              ready,
  output logic [NUM_CH-1:0] cen
`ifdef PLL_CEN_PHASE_EN
  ,
  output logic [NUM_CH-1:0] cen_n
`endif
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(LOCK_DLY + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_DLY - 1);

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               lk_meta, lk;
  logic [CNT_W-1:0]   lock_cnt;
  logic               cfg_ready_q;
  logic [ACC_W-1:0]   inc_q [NUM_CH];
  logic [ACC_W-1:0]   acc_q [NUM_CH];
  logic [ACC_W:0]     sum   [NUM_CH];
  logic [NUM_CH-1:0]  cen_q;
  logic               xfer;
  logic               ch_ok;
  logic               sync_en;
  logic               acc_clr;

  // Lock synchroniser: pll_locked comes straight from the PLL, unrelated to refclk.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= pll_locked;
      lk      <= lk_meta;
    end
  end

  // Counts consecutive locked cycles; any drop restarts qualification from zero.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (state_q == WAIT_LOCK && lk) begin
      if (lock_cnt != {CNT_W{1'b1}}) lock_cnt <= lock_cnt + 1'b1;
    end else begin
      lock_cnt <= '0;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) state_q <= WAIT_LOCK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_LOCK: if (lk && lock_cnt == LOCK_LAST) state_d = RUN;
      RUN:       if (!lk) state_d = WAIT_LOCK;
      default:   state_d = WAIT_LOCK;
    endcase
  end

  assign ready = (state_q == RUN);

  // Config handshake. cfg_ready comes from a flop so it rises only once reset has
  // been released internally.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) cfg_ready_q <= 1'b0;
    else     cfg_ready_q <= 1'b1;
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign xfer    = cfg.cfg_valid & cfg_ready_q;
  assign ch_ok   = (int'(cfg.cfg_ch) < NUM_CH);
  assign sync_en = xfer & ch_ok & cfg.cfg_sync;

  // Increment registers survive lock loss; only reset restores INIT_INC.
  // An out-of-range cfg_ch matches no channel, so the write is dropped.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) inc_q[i] <= INIT_INC[i*ACC_W +: ACC_W];
    end else if (xfer) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg.cfg_ch == CH_W'(i)) inc_q[i] <= cfg.cfg_inc;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
    end
  end

  // Accumulators only run in RUN with lock still present. Holding them at zero
  // otherwise makes the first pulse after ready land a fixed ceil(2^ACC_W/inc)
  // cycles later; a sync write zeroes them all for cross-channel phase alignment.
  assign acc_clr = (state_q != RUN) | ~lk | sync_en;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      cen_q <= '0;
    end else if (acc_clr) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      cen_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= sum[i][ACC_W-1:0];
        cen_q[i] <= sum[i][ACC_W];
      end
    end
  end

  assign cen = cen_q;

`ifdef PLL_CEN_PHASE_EN
  // Accumulator MSB rising marks the half-way point of each period.
  logic [NUM_CH-1:0] cen_n_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cen_n_q <= '0;
    end else if (acc_clr) begin
      cen_n_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cen_n_q[i] <= sum[i][ACC_W-1] & ~acc_q[i][ACC_W-1];
      end
    end
  end

  assign cen_n = cen_n_q;
`endif

endmodule

// File: tb/tb_pll_cen_gen.sv
// Purpose : directed self-checking bench for pll_cen_gen (3 channels, 16-bit accumulators).
// Latency : expected pulse positions are hand-derived from inc and LOCK_DLY=16.
// Backpressure: config driven on the falling edge, accepted on the next rising edge.
module tb_pll_cen_gen;
  localparam int NUM_CH   = 3;
  localparam int ACC_W    = 16;
  localparam int LOCK_DLY = 16;

  logic              refclk;
  logic              rst;
  logic              pll_locked;
  logic              ready;
  logic [NUM_CH-1:0] cen;
`ifdef PLL_CEN_PHASE_EN
  logic [NUM_CH-1:0] cen_n;
`endif

  int n_checks = 0;
  int n_errors = 0;

  pll_cen_gen_if #(.NUM_CH(NUM_CH), .ACC_W(ACC_W)) cfg_if ();

  pll_cen_gen #(
    .NUM_CH  (NUM_CH),
    .ACC_W   (ACC_W),
    .LOCK_DLY(LOCK_DLY),
    .INIT_INC({16'h1000, 16'h1000, 16'h1000})
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .cfg       (cfg_if.slave),
    .ready     (ready),
    .cen       (cen)
`ifdef PLL_CEN_PHASE_EN
    ,
    .cen_n     (cen_n)
`endif
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One rising edge, then park on the falling edge for sampling/driving.
  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic cfg_put(input logic [1:0] ch, input logic [15:0] inc, input logic sync);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_inc   = inc;
    cfg_if.cfg_sync  = sync;
    step();
  endtask

  task automatic cfg_idle();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_sync  = 1'b0;
  endtask

  // Edges until cen[ch] is seen high (at least one edge), bounded.
  task automatic wait_cen(input int ch, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!cen[ch] && cnt < 200);
  endtask

  initial begin
    int cnt;
    int hits;
    int c0, c1, c2, low0, first1;

    rst              = 1'b1;
    pll_locked       = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_inc   = '0;
    cfg_if.cfg_sync  = 1'b0;

    repeat (3) step();
    chk("rst_ready", ready, 0);
    chk("rst_cen", cen, 0);
    chk("rst_cfg_ready", cfg_if.cfg_ready, 0);

    rst = 1'b0;
    step();
    chk("cfg_ready_up", cfg_if.cfg_ready, 1);

    // Clean lock: 2 sync flops + LOCK_DLY counter cycles.
    pll_locked = 1'b1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!ready && cnt < 200);
    chk("lock_latency", cnt, 18);

    wait_cen(0, cnt);
    chk("first_cen", cnt, 16);
    wait_cen(0, cnt);
    chk("cen_period", cnt, 16);

    // Lock drop in RUN: synchroniser delay, then the state change.
    pll_locked = 1'b0;
    step();
    step();
    chk("drop_hold_ready", ready, 1);
    step();
    chk("drop_ready", ready, 0);
    chk("drop_cen", cen, 0);
    chk("drop_cfg_ready", cfg_if.cfg_ready, 1);

    // Relock with a one-cycle glitch seen when the counter is at 10.
    pll_locked = 1'b1;
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == 10) pll_locked = 1'b0;
      if (cnt == 11) pll_locked = 1'b1;
    end while (!ready && cnt < 200);
    chk("glitch_latency", cnt, 29);

    // Push ch1 half a step ahead, then realign everything with a sync write.
    cfg_put(2'd1, 16'h1800, 1'b0);
    cfg_put(2'd1, 16'h1000, 1'b0);
    cfg_idle();
    repeat (5) step();
    cfg_put(2'd0, 16'h1000, 1'b1);
    cfg_idle();
    hits = 0;
    for (int n = 1; n <= 16; n++) begin
      step();
      if (n < 16 && cen != 0) hits++;
`ifdef PLL_CEN_PHASE_EN
      if (n == 8) chk("cen_n_after_sync", cen_n, 3'b111);
`endif
    end
    chk("sync_quiet", hits, 0);
    chk("sync_align", cen, 3'b111);

    // Out-of-range channel with sync: nothing may change, pulses stay on grid.
    cfg_put(2'd3, 16'h0000, 1'b1);
    cfg_idle();
    hits = 0;
    for (int n = 18; n <= 32; n++) begin
      step();
      if (n < 32 && cen != 0) hits++;
`ifdef PLL_CEN_PHASE_EN
      if (n == 24) chk("cen_n_offset", cen_n, 3'b111);
`endif
    end
    chk("badch_quiet", hits, 0);
    chk("badch_phase", cen, 3'b111);

    // Rate window: ch0=0xFFFF, ch1=0x0AAB, ch2=0, back-to-back with sync on the last.
    cfg_put(2'd0, 16'hFFFF, 1'b0);
    cfg_put(2'd1, 16'h0AAB, 1'b0);
    cfg_put(2'd2, 16'h0000, 1'b1);
    cfg_idle();
    c0 = 0; c1 = 0; c2 = 0; low0 = 0; first1 = 0;
    for (int n = 1; n <= 65536; n++) begin
      step();
      if (cen[0]) c0++;
      else if (low0 == 0) low0 = n;
      if (cen[1]) begin
        c1++;
        if (first1 == 0) first1 = n;
      end
      if (cen[2]) c2++;
    end
    chk("ffff_count", c0, 65535);
    chk("ffff_low_pos", low0, 1);
    chk("aab_count", c1, 2731);
    chk("aab_first", first1, 24);
    chk("zero_count", c2, 0);

    // Asynchronous reset while cen[0] is high.
    step();
    step();
    chk("pre_rst_cen0", cen[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cen", cen, 0);
    chk("async_rst_ready", ready, 0);
    chk("async_rst_cfg_ready", cfg_if.cfg_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
